descrambler: RTL and testbench

DESCRAMBLER -- requirements
Module: descrambler

---
 rtl/descrambler_pkg.sv | 34 +++
 rtl/descrambler_lfsr_byte_step.sv | 31 +++
 rtl/descrambler.sv | 164 ++++++++++++++++
 tb/tb_descrambler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/descrambler_pkg.sv
// rtl/descrambler_pkg.sv - shared PHY RX constants and types for the lane descrambler
package descrambler_pkg;

    // 8b/10b scrambler: G(x)=x^16+x^5+x^4+x^3+1, Galois feedback taps below x^16
    localparam logic [15:0] LFSR16_POLY = 16'h0039;
    localparam logic [15:0] LFSR16_INIT = 16'hFFFF;

    // 128b/130b scrambler: G(x)=x^23+x^21+x^16+x^8+x^5+x^2+1, taps below x^23
    localparam logic [22:0] LFSR23_POLY = 23'h210125;

    localparam logic [7:0] COM_CODE    = 8'hBC;
    localparam logic [7:0] SKP_CODE    = 8'h1C;
    localparam logic [7:0] SKP_OS_CODE = 8'hAA;
    localparam logic [7:0] EIEOS_CODE  = 8'h00;

    localparam logic [1:0] SYNC_8B10B = 2'b00;
    localparam logic [1:0] SYNC_OS    = 2'b01;

    typedef enum logic [1:0] {
        BLK_DATA,
        BLK_SKP_OS,
        BLK_EIEOS,
        BLK_OTHER_OS
    } blockKind_t;

    // Per-byte result handed from one byte lane of the chain to the next
    typedef struct packed {
        logic [22:0] state;
        logic [3:0]  count;
        blockKind_t  kind;
        logic [7:0]  data;
    } byteResult_t;

endpackage

// File: rtl/descrambler_lfsr_byte_step.sv
// rtl/descrambler_lfsr_byte_step.sv - eight-step LFSR advance for either scrambler polynomial
//
// Ports:
//   mode128  : 1 = 23-bit 128b/130b polynomial, 0 = 16-bit 8b/10b polynomial (state[15:0])
//   stateIn  : LFSR state before the byte
//   stateOut : LFSR state after eight steps
//   mask     : eight LFSR output bits, bit 0 produced first
module descrambler_lfsr_byte_step
    import descrambler_pkg::*;
(
    input  logic        mode128,
    input  logic [22:0] stateIn,
    output logic [22:0] stateOut,
    output logic [7:0]  mask
);

    always_comb begin
        stateOut = stateIn;
        mask     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (mode128) begin
                mask[i]  = stateOut[22];
                stateOut = {stateOut[21:0], 1'b0} ^ (mask[i] ? LFSR23_POLY : 23'h0);
            end else begin
                mask[i]  = stateOut[15];
                stateOut = {7'h0, {stateOut[14:0], 1'b0} ^ (mask[i] ? LFSR16_POLY : 16'h0)};
            end
        end
    end

endmodule

// File: rtl/descrambler.sv
// rtl/descrambler.sv - one-lane PCIe RX descrambler, 8b/10b and 128b/130b, 1-4 bytes per clock
//
// Ports:
//   clk, reset (sync, active low)       : clock and reset
//   turnOff                             : bypass, data passes unchanged, LFSR still tracks
//   PIPEDataValid/PIPEWIDTH/PIPEData/K  : received word, width 8/16/32 bits
//   PIPESyncHeader                      : 00 = 8b/10b, 01 = ordered-set block, 10 = data block
//   seedValue                           : 128b/130b LFSR seed, bits [22:0]
//   descrambler*                        : registered outputs, one clock after the input
module descrambler
    import descrambler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        turnOff,
    input  logic        PIPEDataValid,
    input  logic [5:0]  PIPEWIDTH,
    input  logic [1:0]  PIPESyncHeader,
    input  logic [23:0] seedValue,
    input  logic [31:0] PIPEData,
    input  logic [3:0]  PIPEDataK,
    output logic        descramblerDataValid,
    output logic [31:0] descramblerData,
    output logic [3:0]  descramblerDataK,
    output logic [1:0]  descramblerSyncHeader
);

    logic [15:0] lfsr16;
    logic [22:0] lfsr23;
    logic [3:0]  byteCount;
    blockKind_t  blockKind;
    logic        lastMode8b10b;

    logic        mode8b10b;
    logic        modeChange;
    logic        wide2;
    logic        wide4;
    logic [22:0] seed;
    logic [22:0] startState;
    logic [3:0]  startCount;
    blockKind_t  startKind;
    logic        unusedSeedMsb;

    logic [22:0] step0State, step1State, step2State, step3State;
    logic [7:0]  step0Mask, step1Mask, step2Mask, step3Mask;
    byteResult_t r0, r1, r2, r3;

    assign seed          = seedValue[22:0];
    assign unusedSeedMsb = seedValue[23];
    assign mode8b10b     = (PIPESyncHeader == SYNC_8B10B);
    assign modeChange    = (mode8b10b != lastMode8b10b);
    // Widths other than 8 and 16 fall through to the full 4-byte word
    assign wide2         = (PIPEWIDTH != 6'd8);
    assign wide4         = wide2 && (PIPEWIDTH != 6'd16);

    // Switching between 8b/10b and 128b/130b restarts the scrambler before this word
    assign startState = mode8b10b ? (modeChange ? {7'h0, LFSR16_INIT} : {7'h0, lfsr16})
                                  : (modeChange ? seed : lfsr23);
    assign startCount = modeChange ? 4'd0 : byteCount;
    assign startKind  = modeChange ? BLK_DATA : blockKind;

    // Block type is decided by the first byte of a 128b/130b block
    function automatic blockKind_t classifyBlock(input logic [1:0] hdr, input logic [7:0] firstByte);
        if (hdr != SYNC_OS)                return BLK_DATA;
        else if (firstByte == SKP_OS_CODE) return BLK_SKP_OS;
        else if (firstByte == EIEOS_CODE)  return BLK_EIEOS;
        else                               return BLK_OTHER_OS;
    endfunction

    function automatic byteResult_t processByte(
        input logic        active,
        input logic        is8b10b,
        input logic        bypass,
        input logic [1:0]  hdr,
        input logic [22:0] seedIn,
        input logic [22:0] st,
        input logic [22:0] stepped,
        input logic [7:0]  mask,
        input logic [7:0]  b,
        input logic        k,
        input logic [3:0]  cnt,
        input blockKind_t  kind
    );
        byteResult_t r;
        blockKind_t  kindNow;
        logic [7:0]  plain;
        r.state = st;
        r.count = cnt;
        r.kind  = kind;
        r.data  = 8'h00;
        plain   = b;
        if (active) begin
            if (is8b10b) begin
                if (k && b == COM_CODE) begin
                    r.state = {7'h0, LFSR16_INIT};
                end else if (k && b == SKP_CODE) begin
                    r.state = st;
                end else begin
                    r.state = stepped;
                    if (!k) plain = b ^ mask;
                end
            end else begin
                kindNow = (cnt == 4'd0) ? classifyBlock(hdr, b) : kind;
                r.kind  = kindNow;
                case (kindNow)
                    BLK_DATA: begin
                        r.state = stepped;
                        plain   = b ^ mask;
                    end
                    BLK_SKP_OS: r.state = st;
                    // EIEOS advances normally, then the last byte reloads the seed
                    BLK_EIEOS:  r.state = (cnt == 4'd15) ? seedIn : stepped;
                    default:    r.state = stepped;
                endcase
                r.count = cnt + 4'd1;
            end
            r.data = bypass ? b : plain;
        end
        return r;
    endfunction

    descrambler_lfsr_byte_step u_step0 (.mode128(!mode8b10b), .stateIn(startState), .stateOut(step0State), .mask(step0Mask));
    descrambler_lfsr_byte_step u_step1 (.mode128(!mode8b10b), .stateIn(r0.state),   .stateOut(step1State), .mask(step1Mask));
    descrambler_lfsr_byte_step u_step2 (.mode128(!mode8b10b), .stateIn(r1.state),   .stateOut(step2State), .mask(step2Mask));
    descrambler_lfsr_byte_step u_step3 (.mode128(!mode8b10b), .stateIn(r2.state),   .stateOut(step3State), .mask(step3Mask));

    assign r0 = processByte(1'b1,  mode8b10b, turnOff, PIPESyncHeader, seed, startState, step0State, step0Mask,
                            PIPEData[7:0],   PIPEDataK[0], startCount, startKind);
    assign r1 = processByte(wide2, mode8b10b, turnOff, PIPESyncHeader, seed, r0.state, step1State, step1Mask,
                            PIPEData[15:8],  PIPEDataK[1], r0.count, r0.kind);
    assign r2 = processByte(wide4, mode8b10b, turnOff, PIPESyncHeader, seed, r1.state, step2State, step2Mask,
                            PIPEData[23:16], PIPEDataK[2], r1.count, r1.kind);
    assign r3 = processByte(wide4, mode8b10b, turnOff, PIPESyncHeader, seed, r2.state, step3State, step3Mask,
                            PIPEData[31:24], PIPEDataK[3], r2.count, r2.kind);

    always_ff @(posedge clk) begin
        if (!reset) begin
            descramblerDataValid  <= 1'b0;
            descramblerData       <= 32'h0;
            descramblerDataK      <= 4'h0;
            descramblerSyncHeader <= 2'b00;
            lfsr16                <= LFSR16_INIT;
            lfsr23                <= seed;
            byteCount             <= 4'd0;
            blockKind             <= BLK_DATA;
            lastMode8b10b         <= 1'b1;
        end else begin
            descramblerDataValid  <= PIPEDataValid;
            descramblerDataK      <= PIPEDataK;
            descramblerSyncHeader <= PIPESyncHeader;
            if (PIPEDataValid) begin
                descramblerData <= {r3.data, r2.data, r1.data, r0.data};
                lfsr16          <= mode8b10b ? r3.state[15:0] : (modeChange ? LFSR16_INIT : lfsr16);
                lfsr23          <= mode8b10b ? (modeChange ? seed : lfsr23) : r3.state;
                byteCount       <= r3.count;
                blockKind       <= r3.kind;
                lastMode8b10b   <= mode8b10b;
            end else begin
                descramblerData <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_descrambler.sv
// tb/tb_descrambler.sv - directed self-checking bench for descrambler
module tb_descrambler;

    logic        clk = 1'b0;
    logic        reset;
    logic        turnOff;
    logic        PIPEDataValid;
    logic [5:0]  PIPEWIDTH;
    logic [1:0]  PIPESyncHeader;
    logic [23:0] seedValue;
    logic [31:0] PIPEData;
    logic [3:0]  PIPEDataK;
    logic        descramblerDataValid;
    logic [31:0] descramblerData;
    logic [3:0]  descramblerDataK;
    logic [1:0]  descramblerSyncHeader;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [22:0] refState;
    logic [31:0] word;
    logic [31:0] mask;

    descrambler dut (
        .clk(clk),
        .reset(reset),
        .turnOff(turnOff),
        .PIPEDataValid(PIPEDataValid),
        .PIPEWIDTH(PIPEWIDTH),
        .PIPESyncHeader(PIPESyncHeader),
        .seedValue(seedValue),
        .PIPEData(PIPEData),
        .PIPEDataK(PIPEDataK),
        .descramblerDataValid(descramblerDataValid),
        .descramblerData(descramblerData),
        .descramblerDataK(descramblerDataK),
        .descramblerSyncHeader(descramblerSyncHeader)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one word, let it cross one clock edge, sample just after that edge
    task automatic step(input logic v, input logic [5:0] w, input logic [1:0] h,
                        input logic [31:0] d, input logic [3:0] k);
        PIPEDataValid  = v;
        PIPEWIDTH      = w;
        PIPESyncHeader = h;
        PIPEData       = d;
        PIPEDataK      = k;
        @(posedge clk);
        #1;
    endtask

    // Reference 128b/130b scrambler: multiply by x modulo the full 24-bit polynomial
    task automatic nextMask(output logic [31:0] m);
        logic [23:0] t;
        m = 32'h0;
        for (int i = 0; i < 32; i++) begin
            m[i] = refState[22];
            t    = {refState, 1'b0};
            if (t[23]) t = t ^ 24'hA10125;
            refState = t[22:0];
        end
    endtask

    initial begin
        reset          = 1'b0;
        turnOff        = 1'b0;
        seedValue      = 24'h0;
        PIPEDataValid  = 1'b0;
        PIPEWIDTH      = 6'd8;
        PIPESyncHeader = 2'b00;
        PIPEData       = 32'h0;
        PIPEDataK      = 4'h0;

        // Reset wins over a valid input
        step(1'b1, 6'd8, 2'b01, 32'hDEADBEEF, 4'hF);
        checkValue("rst1_valid", {31'h0, descramblerDataValid}, 32'h0);
        checkValue("rst1_data", descramblerData, 32'h0);
        step(1'b1, 6'd8, 2'b01, 32'hDEADBEEF, 4'hF);
        checkValue("rst2_valid", {31'h0, descramblerDataValid}, 32'h0);
        checkValue("rst2_data", descramblerData, 32'h0);
        checkValue("rst2_k", {28'h0, descramblerDataK}, 32'h0);
        checkValue("rst2_hdr", {30'h0, descramblerSyncHeader}, 32'h0);
        reset = 1'b1;

        // LFSR sits at FFFF after reset: first data byte 00 descrambles to FF
        step(1'b1, 6'd8, 2'b00, 32'h00000000, 4'h0);
        checkValue("post_rst_ffff", descramblerData, 32'h000000FF);
        checkValue("post_rst_valid", {31'h0, descramblerDataValid}, 32'h1);

        // COM, 00, 00 -> BC, FF, 17
        step(1'b1, 6'd8, 2'b00, 32'h000000BC, 4'h1);
        checkValue("com_data", descramblerData, 32'h000000BC);
        checkValue("com_k", {28'h0, descramblerDataK}, 32'h1);
        step(1'b1, 6'd8, 2'b00, 32'h00000000, 4'h0);
        checkValue("com_d1", descramblerData, 32'h000000FF);
        step(1'b1, 6'd8, 2'b00, 32'h00000000, 4'h0);
        checkValue("com_d2", descramblerData, 32'h00000017);

        // COM, SKP, 00 -> SKP does not advance the LFSR
        step(1'b1, 6'd8, 2'b00, 32'h000000BC, 4'h1);
        step(1'b1, 6'd8, 2'b00, 32'h0000001C, 4'h1);
        checkValue("skp_data", descramblerData, 32'h0000001C);
        checkValue("skp_k", {28'h0, descramblerDataK}, 32'h1);
        step(1'b1, 6'd8, 2'b00, 32'h00000000, 4'h0);
        checkValue("skp_then_d", descramblerData, 32'h000000FF);

        // Four bytes chained in one clock: BC, FF, 17, C0
        step(1'b1, 6'd32, 2'b00, 32'h000000BC, 4'h1);
        checkValue("w32_chain", descramblerData, 32'hC017FFBC);
        // Width 24 is not legal and behaves as 32
        step(1'b1, 6'd24, 2'b00, 32'h000000BC, 4'h1);
        checkValue("w24_as_32", descramblerData, 32'hC017FFBC);

        // Bypass: masked to width, LFSR still consumes two bytes (FF, 17)
        step(1'b1, 6'd8, 2'b00, 32'h000000BC, 4'h1);
        turnOff = 1'b1;
        step(1'b1, 6'd16, 2'b00, 32'hAABBCCDD, 4'h0);
        checkValue("bypass_data", descramblerData, 32'h0000CCDD);
        checkValue("bypass_valid", {31'h0, descramblerDataValid}, 32'h1);
        turnOff = 1'b0;
        step(1'b1, 6'd8, 2'b00, 32'h00000000, 4'h0);
        checkValue("bypass_lfsr_tracked", descramblerData, 32'h000000C0);

        // Valid 1,0,1: idle word emits zero and holds the LFSR
        step(1'b1, 6'd8, 2'b00, 32'h000000BC, 4'h1);
        step(1'b1, 6'd8, 2'b00, 32'h00000000, 4'h0);
        checkValue("tog_d1", descramblerData, 32'h000000FF);
        checkValue("tog_v1", {31'h0, descramblerDataValid}, 32'h1);
        step(1'b0, 6'd8, 2'b00, 32'h00000055, 4'h0);
        checkValue("tog_v0", {31'h0, descramblerDataValid}, 32'h0);
        checkValue("tog_d0", descramblerData, 32'h0);
        step(1'b1, 6'd8, 2'b00, 32'h00000000, 4'h0);
        checkValue("tog_d2", descramblerData, 32'h00000017);
        checkValue("tog_v2", {31'h0, descramblerDataValid}, 32'h1);

        // 128b/130b, seed 0: SKP OS block then data block
        seedValue = 24'h0;
        refState  = 23'h0;
        for (int i = 0; i < 4; i++) begin
            word = (i == 0) ? 32'hAAAAAAAA : 32'h5A5A0000 + i;
            step(1'b1, 6'd32, 2'b01, word, 4'h0);
            checkValue("s0_skpos", descramblerData, word);
        end
        checkValue("s0_hdr", {30'h0, descramblerSyncHeader}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            word = 32'h01234567 + i * 32'h11111111;
            nextMask(mask);
            step(1'b1, 6'd32, 2'b10, word, 4'h0);
            checkValue("s0_data", descramblerData, word ^ mask);
        end

        // Nonzero seed: a trip through 8b/10b makes the next block reload it
        seedValue = 24'h5A3C96;
        step(1'b1, 6'd8, 2'b00, 32'h00000000, 4'h0);
        refState = 23'h5A3C96;
        for (int i = 0; i < 4; i++) begin
            word = (i == 0) ? 32'h332211AA : 32'hC0DE0000 + i;
            step(1'b1, 6'd32, 2'b01, word, 4'h0);
            checkValue("skpos_pass", descramblerData, word);
        end
        for (int i = 0; i < 4; i++) begin
            word = 32'h89ABCDEF - i * 32'h01010101;
            nextMask(mask);
            step(1'b1, 6'd32, 2'b10, word, 4'h0);
            checkValue("seed_data1", descramblerData, word ^ mask);
        end

        // Other ordered set: passes unchanged, LFSR advances 16 bytes
        for (int i = 0; i < 4; i++) begin
            word = (i == 0) ? 32'h4455662D : 32'h0F0F0F0F;
            nextMask(mask);
            step(1'b1, 6'd32, 2'b01, word, 4'h0);
            checkValue("os_pass", descramblerData, word);
        end
        for (int i = 0; i < 4; i++) begin
            word = 32'h00000000;
            nextMask(mask);
            step(1'b1, 6'd32, 2'b10, word, 4'h0);
            checkValue("seed_data2", descramblerData, mask);
        end

        // EIEOS: passes unchanged, LFSR reloads the seed at block end
        for (int i = 0; i < 4; i++) begin
            word = 32'hFF00FF00;
            step(1'b1, 6'd32, 2'b01, word, 4'h0);
            checkValue("eieos_pass", descramblerData, word);
        end
        refState = 23'h5A3C96;
        nextMask(mask);
        step(1'b1, 6'd32, 2'b10, 32'h13579BDF, 4'h0);
        checkValue("eieos_reload", descramblerData, 32'h13579BDF ^ mask);

        // Reset in the middle of a block clears outputs and restarts from the seed
        reset = 1'b0;
        step(1'b1, 6'd32, 2'b10, 32'hFFFFFFFF, 4'h0);
        checkValue("midblk_rst_valid", {31'h0, descramblerDataValid}, 32'h0);
        checkValue("midblk_rst_data", descramblerData, 32'h0);
        reset = 1'b1;
        refState = 23'h5A3C96;
        nextMask(mask);
        step(1'b1, 6'd32, 2'b10, 32'h2468ACE0, 4'h0);
        checkValue("midblk_rst_restart", descramblerData, 32'h2468ACE0 ^ mask);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
